clk_div_gen: RTL and testbench
==============================

# clk_div_gen

Parametrised multi-channel clock divider for the filter datapath. It produces, per channel, a one-cycle clock-enable pulse (`tick`) and a registered square wave (`clk_out`) at `clk / D`. The divisor D can be reprogrammed at runtime through a valid/ready port. Downstream logic (VGA timing, pixel pipeline) runs on `clk` and qualifies with `tick`; `clk_out` exists only for pins and probes and must not be used as a fabric clock. With `NUM_CH=1` and `D=2`, `clk_out` matches the legacy 25 MHz divide-by-2 output.

## Interface
- `NUM_CH`, default 2: number of independent divider channels (1..8).
- `DIV_W`, default 16: divisor and counter width.
- `DEFAULT_DIV`, default 2: divisor loaded into every channel at reset; must be ≥1.
- `clk`, in, 1: single system clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `en`, in, `NUM_CH`: per-channel run enable.
- `cfg_valid`, in, 1: configuration request.
- `cfg_ready`, out, 1: combinational, equals `!pend[cfg_ch]`; 1 when `cfg_ch` is out of range.
- `cfg_ch`, in, `CH_W = max(1, clog2(NUM_CH))`: target channel.
- `cfg_div`, in, `DIV_W`: new divisor D.
- `cfg_sync`, in, 1: apply immediately and phase-align all channels.
- `cfg_err`, out, 1: one-cycle pulse when a request is rejected.
- `tick`, out, `NUM_CH`: registered one-cycle enable pulse, once per period.
- `clk_out`, out, `NUM_CH`: registered square wave.

## Operation
- A request is accepted when `cfg_valid && cfg_ready`.
- Rejection: `cfg_div == 0` or `cfg_ch ≥ NUM_CH`. The request is still accepted; `cfg_err` pulses on the next cycle and there is no other effect.
- Per channel state:
  - `cnt` (`DIV_W` bits), `div`, `pend_div`, and the `pend` flag.
  - While `en` is high: `cnt` counts 0..`div-1`, then wraps to 0.
  - `wrap = en && cnt == div-1`.
  - `HI = (div+1) >> 1`, so the high phase is ceil(D/2) cycles.
- Non-sync update: `pend_div` is loaded and `pend` is set.
  - At the channel's next `wrap`, `div` takes `pend_div` and `pend` clears.
  - Updates are therefore glitch-free, period-boundary aligned, and the current period always completes.
- Accept in the same cycle as that channel's wrap, with no pending update: `div` takes the new value directly at that wrap, and `pend` is never set.
- Sync update (`cfg_sync=1`, legal):
  - The target `div` updates in the next cycle.
  - Every channel's `cnt` is cleared to 0 and every `pend` is discarded.
  - `tick` and `clk_out` of all channels restart phase-aligned.
- Disabled channel (`en=0`):
  - `cnt` is held at 0 and `tick` and `clk_out` are 0.
  - A pending update is applied immediately.
- D=1: `tick` is high every enabled cycle and `clk_out` is constantly 1.
- D wider than the counter is impossible by construction; no saturation logic is required.

## Timing
- Reset values: all `cnt`=0, `div`=`DEFAULT_DIV`, `pend`=0, `tick`=0, `clk_out`=0, `cfg_err`=0. `cfg_ready`=1 after reset.
- `en` rising in cycle 0 (first enabled count at edge 1):
  - `tick` is first high in cycle D, then every D cycles.
  - `clk_out` is high in cycles 1..HI of each period and low for the remaining D−HI cycles.
- Latency: `tick` and `clk_out` are registered, one cycle after the `cnt` state they reflect.
- `en` falling: outputs are 0 from the next cycle. Re-enable restarts the sequence from cnt=0.
- `cfg_err` appears one cycle after acceptance.
- Reset asserted mid-period: outputs clear asynchronously and pending requests are lost.

## Structure
- `clk_div_pkg`: `DIV_W` default, `CH_W` computation, and a `half_hi(div)` function.
- One sub-module, `clk_div_chan`: holds `cnt`, `div`, `pend`, and the `tick`/`clk_out` registers; instantiated `NUM_CH` times via generate.
- The top level owns request decode, `cfg_ready` muxing, sync broadcast, and `cfg_err`.

## Test plan
- Reset then `en`=1 with the default D=2 → `clk_out` toggles every cycle; `tick` pulses every 2nd cycle starting in cycle 2.
- Program ch0 D=5 while running at D=2 → current period finishes, then period 5 with `clk_out` high 3 and low 2. `cfg_ready` is low for ch0 while pending and high for ch1.
- Program ch0 D=7 and ch1 D=3 with `cfg_sync` on the last request → both counters clear in the same cycle; first ticks land at cycles 7 and 3 after the sync, then every 21 cycles coincide.
- `cfg_div=0`, then `cfg_ch=NUM_CH` → each accepted, `cfg_err` pulses one cycle later, outputs undisturbed.
- D=1 → `tick` is continuously high and `clk_out` is 1. Deassert `en` → both are 0 in the next cycle.
- Assert `rst_n`=0 mid-period with an update pending → outputs are 0 immediately. After release, `div`=`DEFAULT_DIV` and the pending update is lost.

Source files
------------

// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_pkg
// Description : Shared constants and helpers for the clk_div_gen divider
//               slice: default divisor width, channel-select width and the
//               high-phase length of a divide-by-D square wave.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    localparam int c_div_w_default = 16;

    // Width of the channel-select field; a single channel still needs one bit.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // High-phase length in cycles: ceil(D/2).
    function automatic logic [31:0] half_hi(input logic [31:0] div);
        return (div + 32'd1) >> 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_gen_if
// Description : Runtime divisor configuration port (valid/ready request plus
//               one-cycle error pulse).
//   cfg_valid  : request present
//   cfg_ready  : target channel can take a request
//   cfg_ch     : target channel
//   cfg_div    : new divisor
//   cfg_sync   : apply now and phase-align every channel
//   cfg_err    : pulse one cycle after a rejected request
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_div_gen_if
    import clk_div_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = c_div_w_default
);
    localparam int CH_W = ch_width(NUM_CH);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_sync;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_div, cfg_sync,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div, cfg_sync,
        output cfg_ready, cfg_err
    );

endinterface
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_chan
// Description : One divider channel. Counts 0..div-1 while enabled and emits
//               a registered tick on the wrap cycle and a registered square
//               wave that is high for the first ceil(div/2) counts.
//   clk, rst_n : system clock, asynchronous active-low reset
//   en         : run enable
//   upd        : legal accepted request aimed at this channel
//   upd_div    : divisor carried by that request
//   sync       : legal accepted sync request (any channel) - restart all
//   pend       : an update is waiting for the next period boundary
//   tick       : one-cycle pulse per period
//   clk_out    : square wave at clk/div
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = c_div_w_default,
    parameter int DEFAULT_DIV = 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             en,
    input  wire logic             upd,
    input  wire logic [DIV_W-1:0] upd_div,
    input  wire logic             sync,
    output logic                  pend,
    output logic                  tick,
    output logic                  clk_out
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_pend_div;
    logic             r_pend;
    logic             r_tick;
    logic             r_clk_out;

    logic             w_last;
    logic             w_wrap;
    logic             w_bound;
    logic [DIV_W-1:0] w_hi;

    assign w_last  = (r_cnt == r_div - DIV_W'(1));
    assign w_wrap  = en && w_last;
    // Divisor may change at a period boundary, or at any time while idle
    // because the counter is parked at 0 then.
    assign w_bound = w_wrap || !en;
    assign w_hi    = DIV_W'(half_hi(32'(r_div)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_div      <= DIV_W'(DEFAULT_DIV);
            r_pend_div <= '0;
            r_pend     <= 1'b0;
            r_tick     <= 1'b0;
            r_clk_out  <= 1'b0;
        end else if (sync) begin
            // Every channel restarts from cnt=0 with outputs low, so the
            // following cycle behaves like the first cycle after enable.
            r_cnt     <= '0;
            r_pend    <= 1'b0;
            r_tick    <= 1'b0;
            r_clk_out <= 1'b0;
            if (upd) begin
                r_div <= upd_div;
            end
        end else begin
            r_tick    <= w_wrap;
            r_clk_out <= en && (r_cnt < w_hi);

            if (!en || w_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + DIV_W'(1);
            end

            // upd only arrives with no update pending (ready gating).
            if (upd && w_bound) begin
                r_div  <= upd_div;
                r_pend <= 1'b0;
            end else if (upd) begin
                r_pend_div <= upd_div;
                r_pend     <= 1'b1;
            end else if (r_pend && w_bound) begin
                r_div  <= r_pend_div;
                r_pend <= 1'b0;
            end
        end
    end

    assign pend    = r_pend;
    assign tick    = r_tick;
    assign clk_out = r_clk_out;

endmodule
`default_nettype wire

// File: rtl/clk_div_gen.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_gen
// Description : Multi-channel clock divider producing per-channel tick
//               enables and square waves at clk/D, with runtime divisor
//               reprogramming. Decodes configuration requests, muxes ready
//               from the selected channel, broadcasts sync and flags errors.
//   clk, rst_n : system clock, asynchronous active-low reset
//   en         : per-channel run enable
//   cfg        : configuration port (slave side)
//   tick       : per-channel one-cycle pulse per period
//   clk_out    : per-channel square wave (pins/probes only)
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = c_div_w_default,
    parameter int DEFAULT_DIV = 2
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic [NUM_CH-1:0] en,
    clk_div_gen_if.slave           cfg,
    output logic      [NUM_CH-1:0] tick,
    output logic      [NUM_CH-1:0] clk_out
);

    localparam int CH_W = ch_width(NUM_CH);
    localparam logic [CH_W:0] c_num_ch = (CH_W + 1)'(NUM_CH);

    logic [NUM_CH-1:0] w_pend;
    logic              w_pend_sel;
    logic              w_in_range;
    logic              w_accept;
    logic              w_legal;
    logic              w_ok;
    logic              w_sync;
    logic              r_err;

    assign w_in_range = ({1'b0, cfg.cfg_ch} < c_num_ch);

    // Compare-based select keeps out-of-range channels from indexing w_pend.
    always_comb begin
        w_pend_sel = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg.cfg_ch == CH_W'(i)) begin
                w_pend_sel = w_pend[i];
            end
        end
    end

    assign cfg.cfg_ready = !w_pend_sel;

    assign w_accept = cfg.cfg_valid && cfg.cfg_ready;
    assign w_legal  = w_in_range && (cfg.cfg_div != '0);
    assign w_ok     = w_accept && w_legal;
    assign w_sync   = w_ok && cfg.cfg_sync;

    // Rejected requests are consumed but only raise the error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept && !w_legal;
        end
    end

    assign cfg.cfg_err = r_err;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        clk_div_chan #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en[i]),
            .upd     (w_ok && (cfg.cfg_ch == CH_W'(i))),
            .upd_div (cfg.cfg_div),
            .sync    (w_sync),
            .pend    (w_pend[i]),
            .tick    (tick[i]),
            .clk_out (clk_out[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_gen
// Description : Directed self-checking bench for clk_div_gen with three
//               channels (channel 2 left disabled). Cycle k is the interval
//               after clock edge k; outputs are sampled 1 ns after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_gen;
    import clk_div_pkg::*;

    localparam int NUM_CH      = 3;
    localparam int DIV_W       = 16;
    localparam int DEFAULT_DIV = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] clk_out;

    clk_div_gen_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) cfg_if ();

    clk_div_gen #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .cfg     (cfg_if),
        .tick    (tick),
        .clk_out (clk_out)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        en               = '0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_div   = '0;
        cfg_if.cfg_sync  = 1'b0;
        rst_n            = 1'b0;
        step();
        step();
        vectors++;
        if (tick !== 3'b000) begin miscompares++; $display("FAIL reset_tick: got %b expected 000", tick); end
        vectors++;
        if (clk_out !== 3'b000) begin miscompares++; $display("FAIL reset_clk_out: got %b expected 000", clk_out); end
        vectors++;
        if (cfg_if.cfg_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", cfg_if.cfg_err); end
        vectors++;
        if (cfg_if.cfg_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", cfg_if.cfg_ready); end
        // Release reset and enable ch0/ch1 in cycle 0.
        rst_n = 1'b1;
        en    = 3'b011;
        cyc   = 0;
    endtask

    // D=2: clk_out high in odd cycles, tick in even cycles from cycle 2.
    task automatic test_default_div();
        logic [2:0] et, ec;
        for (int k = 1; k <= 8; k++) begin
            step();
            et = {1'b0, (cyc % 2 == 0), (cyc % 2 == 0)};
            ec = {1'b0, (cyc % 2 == 1), (cyc % 2 == 1)};
            vectors++;
            if (tick !== et) begin miscompares++; $display("FAIL default_tick c%0d: got %b expected %b", cyc, tick, et); end
            vectors++;
            if (clk_out !== ec) begin miscompares++; $display("FAIL default_clk c%0d: got %b expected %b", cyc, clk_out, ec); end
        end
    endtask

    // ch0 D=5 requested in cycle 8 (mid-period): takes effect after cycle 9.
    task automatic test_update();
        logic t0, c0;
        logic [2:0] et, ec;
        cfg_if.cfg_ch    = 2'd0;
        cfg_if.cfg_div   = 16'd5;
        cfg_if.cfg_sync  = 1'b0;
        cfg_if.cfg_valid = 1'b1;
        #1;
        vectors++;
        if (cfg_if.cfg_ready !== 1'b1) begin miscompares++; $display("FAIL upd_ready_idle: got %b expected 1", cfg_if.cfg_ready); end
        for (int k = 9; k <= 20; k++) begin
            step();
            if (cyc == 9) begin
                cfg_if.cfg_valid = 1'b0;
                #1;
                vectors++;
                if (cfg_if.cfg_ready !== 1'b0) begin miscompares++; $display("FAIL upd_ready_pend_ch0: got %b expected 0", cfg_if.cfg_ready); end
                cfg_if.cfg_ch = 2'd1;
                #1;
                vectors++;
                if (cfg_if.cfg_ready !== 1'b1) begin miscompares++; $display("FAIL upd_ready_ch1: got %b expected 1", cfg_if.cfg_ready); end
                cfg_if.cfg_ch = 2'd0;
                #1;
            end
            if (cyc == 10) begin
                vectors++;
                if (cfg_if.cfg_ready !== 1'b1) begin miscompares++; $display("FAIL upd_ready_applied: got %b expected 1", cfg_if.cfg_ready); end
            end
            if (cyc <= 10) begin
                t0 = (cyc % 2 == 0);
                c0 = (cyc % 2 == 1);
            end else begin
                t0 = ((cyc - 10) % 5 == 0);
                c0 = ((cyc - 11) % 5 < 3);
            end
            et = {1'b0, (cyc % 2 == 0), t0};
            ec = {1'b0, (cyc % 2 == 1), c0};
            vectors++;
            if (tick !== et) begin miscompares++; $display("FAIL upd_tick c%0d: got %b expected %b", cyc, tick, et); end
            vectors++;
            if (clk_out !== ec) begin miscompares++; $display("FAIL upd_clk c%0d: got %b expected %b", cyc, clk_out, ec); end
        end
    endtask

    // ch0 D=7 (pending until the cycle-24 wrap), then ch1 D=3 with sync in
    // cycle 25. Counters restart at cycle 26; j counts from there.
    task automatic test_sync();
        logic t0, c0, t1, c1;
        int j;
        logic [2:0] et, ec;
        cfg_if.cfg_ch    = 2'd0;
        cfg_if.cfg_div   = 16'd7;
        cfg_if.cfg_sync  = 1'b0;
        cfg_if.cfg_valid = 1'b1;
        for (int k = 21; k <= 47; k++) begin
            step();
            if (cyc == 21) cfg_if.cfg_valid = 1'b0;
            if (cyc == 24 || cyc == 25) begin
                #1;
                vectors++;
                if (cfg_if.cfg_ready !== (cyc == 25)) begin miscompares++; $display("FAIL sync_ready_ch0 c%0d: got %b expected %b", cyc, cfg_if.cfg_ready, (cyc == 25)); end
            end
            if (cyc == 25) begin
                cfg_if.cfg_ch    = 2'd1;
                cfg_if.cfg_div   = 16'd3;
                cfg_if.cfg_sync  = 1'b1;
                cfg_if.cfg_valid = 1'b1;
            end
            if (cyc == 26) begin
                cfg_if.cfg_valid = 1'b0;
                cfg_if.cfg_sync  = 1'b0;
            end
            j = cyc - 26;
            if (cyc <= 25) begin
                t0 = ((cyc - 10) % 5 == 0);
                c0 = ((cyc - 11) % 5 < 3);
                t1 = (cyc % 2 == 0);
                c1 = (cyc % 2 == 1);
            end else begin
                t0 = (j > 0) && (j % 7 == 0);
                c0 = (j > 0) && ((j - 1) % 7 < 4);
                t1 = (j > 0) && (j % 3 == 0);
                c1 = (j > 0) && ((j - 1) % 3 < 2);
            end
            et = {1'b0, t1, t0};
            ec = {1'b0, c1, c0};
            vectors++;
            if (tick !== et) begin miscompares++; $display("FAIL sync_tick c%0d: got %b expected %b", cyc, tick, et); end
            vectors++;
            if (clk_out !== ec) begin miscompares++; $display("FAIL sync_clk c%0d: got %b expected %b", cyc, clk_out, ec); end
        end
        vectors++;
        if (tick[1:0] !== 2'b11) begin miscompares++; $display("FAIL sync_coincide: got %b expected 11", tick[1:0]); end
    endtask

    // Zero divisor then out-of-range channel; outputs keep the sync pattern.
    task automatic test_cfg_error();
        int j;
        logic [2:0] et, ec;
        cfg_if.cfg_ch    = 2'd0;
        cfg_if.cfg_div   = 16'd0;
        cfg_if.cfg_sync  = 1'b0;
        cfg_if.cfg_valid = 1'b1;
        for (int k = 48; k <= 50; k++) begin
            step();
            vectors++;
            if (cfg_if.cfg_err !== (cyc != 50)) begin miscompares++; $display("FAIL err_pulse c%0d: got %b expected %b", cyc, cfg_if.cfg_err, (cyc != 50)); end
            if (cyc == 48) begin
                cfg_if.cfg_ch  = 2'd3;
                cfg_if.cfg_div = 16'd4;
                #1;
                vectors++;
                if (cfg_if.cfg_ready !== 1'b1) begin miscompares++; $display("FAIL err_ready_oor: got %b expected 1", cfg_if.cfg_ready); end
            end
            if (cyc == 49) cfg_if.cfg_valid = 1'b0;
            j  = cyc - 26;
            et = {1'b0, (j % 3 == 0), (j % 7 == 0)};
            ec = {1'b0, ((j - 1) % 3 < 2), ((j - 1) % 7 < 4)};
            vectors++;
            if (tick !== et) begin miscompares++; $display("FAIL err_tick c%0d: got %b expected %b", cyc, tick, et); end
            vectors++;
            if (clk_out !== ec) begin miscompares++; $display("FAIL err_clk c%0d: got %b expected %b", cyc, clk_out, ec); end
        end
        cfg_if.cfg_ch = 2'd0;
        #1;
        vectors++;
        if (cfg_if.cfg_ready !== 1'b1) begin miscompares++; $display("FAIL err_no_pend: got %b expected 1", cfg_if.cfg_ready); end
    endtask

    // ch1 D=1 via sync in cycle 50; disable ch1 in 55, re-enable in 56.
    task automatic test_div_one();
        int j;
        logic t1, c1;
        logic [2:0] et, ec;
        cfg_if.cfg_ch    = 2'd1;
        cfg_if.cfg_div   = 16'd1;
        cfg_if.cfg_sync  = 1'b1;
        cfg_if.cfg_valid = 1'b1;
        for (int k = 51; k <= 57; k++) begin
            step();
            if (cyc == 51) begin
                cfg_if.cfg_valid = 1'b0;
                cfg_if.cfg_sync  = 1'b0;
            end
            if (cyc == 55) en = 3'b001;
            if (cyc == 56) en = 3'b011;
            j  = cyc - 51;
            t1 = (j > 0) && (cyc != 56);
            c1 = t1;
            et = {1'b0, t1, (j > 0) && (j % 7 == 0)};
            ec = {1'b0, c1, (j > 0) && ((j - 1) % 7 < 4)};
            vectors++;
            if (tick !== et) begin miscompares++; $display("FAIL d1_tick c%0d: got %b expected %b", cyc, tick, et); end
            vectors++;
            if (clk_out !== ec) begin miscompares++; $display("FAIL d1_clk c%0d: got %b expected %b", cyc, clk_out, ec); end
        end
    endtask

    // ch0 D=4 left pending (request in 58), reset mid-cycle 59.
    task automatic test_reset_mid();
        logic [2:0] et, ec;
        step();
        cfg_if.cfg_ch    = 2'd0;
        cfg_if.cfg_div   = 16'd4;
        cfg_if.cfg_sync  = 1'b0;
        cfg_if.cfg_valid = 1'b1;
        step();
        cfg_if.cfg_valid = 1'b0;
        #1;
        vectors++;
        if (cfg_if.cfg_ready !== 1'b0) begin miscompares++; $display("FAIL rst_pend_ready: got %b expected 0", cfg_if.cfg_ready); end
        vectors++;
        if (clk_out !== 3'b011) begin miscompares++; $display("FAIL rst_pre_clk: got %b expected 011", clk_out); end
        vectors++;
        if (tick !== 3'b010) begin miscompares++; $display("FAIL rst_pre_tick: got %b expected 010", tick); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (tick !== 3'b000) begin miscompares++; $display("FAIL rst_async_tick: got %b expected 000", tick); end
        vectors++;
        if (clk_out !== 3'b000) begin miscompares++; $display("FAIL rst_async_clk: got %b expected 000", clk_out); end
        step();
        rst_n = 1'b1;
        cyc   = 0;
        #1;
        vectors++;
        if (cfg_if.cfg_ready !== 1'b1) begin miscompares++; $display("FAIL rst_pend_lost: got %b expected 1", cfg_if.cfg_ready); end
        // Both channels back to DEFAULT_DIV=2.
        for (int k = 1; k <= 6; k++) begin
            step();
            et = {1'b0, (cyc % 2 == 0), (cyc % 2 == 0)};
            ec = {1'b0, (cyc % 2 == 1), (cyc % 2 == 1)};
            vectors++;
            if (tick !== et) begin miscompares++; $display("FAIL rst_post_tick c%0d: got %b expected %b", cyc, tick, et); end
            vectors++;
            if (clk_out !== ec) begin miscompares++; $display("FAIL rst_post_clk c%0d: got %b expected %b", cyc, clk_out, ec); end
        end
    endtask

    initial begin
        test_reset();
        test_default_div();
        test_update();
        test_sync();
        test_cfg_error();
        test_div_one();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
